// File: rtl/partition_sweep_ctrl.sv
// Exhaustive input sweep of a partition that compares the exact and approximate
// instance outputs, accumulating error count, Hamming sum and maximum absolute error.
module partition_sweep_ctrl #(
    parameter int unsigned NI     = 7,
    parameter int unsigned NO     = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic [NI-1:0]                 pi,
    input  logic [NO-1:0]                 po_exact,
    input  logic [NO-1:0]                 po_approx,
    output logic                          busy,
    output logic                          done,
    output logic                          result_valid,
    output logic [NI:0]                   err_cnt,
    output logic [NI+$clog2(NO+1)-1:0]    ham_sum,
    output logic [NO-1:0]                 max_abs_err
);

    localparam int unsigned EW = NI + 1;
    localparam int unsigned PW = $clog2(NO + 1);
    localparam int unsigned HW = NI + PW;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [NI-1:0] PI_LAST     = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // With no settle time each new pattern is sampled immediately.
    localparam state_t PAT_STATE = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   settle_cnt;

    logic            accept_c;
    logic            abort_c;
    logic            acc_c;
    logic            hold_settle_c;
    logic            busy_nxt;
    logic            done_nxt;

    logic [NO-1:0]   diff_c;
    logic [PW-1:0]   pop_c;
    logic [NO-1:0]   abs_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = PAT_STATE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (pi == PI_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = PAT_STATE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Control strobes and next values of the registered status outputs
    always_comb begin
        accept_c      = 1'b0;
        abort_c       = 1'b0;
        acc_c         = 1'b0;
        hold_settle_c = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        if (state == S_IDLE) begin
            accept_c = start && !abort;
        end
        if ((state == S_SETTLE) || (state == S_SAMPLE)) begin
            abort_c = abort;
        end
        if ((state == S_SAMPLE) && !abort) begin
            acc_c = 1'b1;
        end
        if ((state == S_SETTLE) && (state_nxt == S_SETTLE)) begin
            hold_settle_c = 1'b1;
        end
        busy_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_SAMPLE);
        done_nxt = (state_nxt == S_DONE);
    end

    // Per-pattern comparison metrics
    always_comb begin
        diff_c = po_exact ^ po_approx;
        pop_c  = '0;
        for (int i = 0; i < int'(NO); i++) begin
            pop_c = pop_c + PW'(diff_c[i]);
        end
        abs_c = (po_exact >= po_approx) ? (po_exact - po_approx) : (po_approx - po_exact);
    end

    // Pattern counter, accumulators and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pi           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            err_cnt      <= '0;
            ham_sum      <= '0;
            max_abs_err  <= '0;
            settle_cnt   <= '0;
        end else begin
            busy       <= busy_nxt;
            done       <= done_nxt;
            settle_cnt <= hold_settle_c ? settle_cnt + CW'(1) : '0;
            if (accept_c) begin
                pi           <= '0;
                err_cnt      <= '0;
                ham_sum      <= '0;
                max_abs_err  <= '0;
                result_valid <= 1'b0;
            end
            if (abort_c) begin
                pi           <= '0;
                result_valid <= 1'b0;
            end
            if (acc_c) begin
                err_cnt <= err_cnt + EW'(|diff_c);
                ham_sum <= ham_sum + HW'(pop_c);
                if (abs_c > max_abs_err) begin
                    max_abs_err <= abs_c;
                end
                // The last pattern leaves pi at all-ones for the DONE cycle.
                if (pi == PI_LAST) begin
                    result_valid <= 1'b1;
                end else begin
                    pi <= pi + NI'(1);
                end
            end
            if (state == S_DONE) begin
                pi <= '0;
            end
        end
    end

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Scoreboard bench: two sweep controllers (SETTLE=1 and SETTLE=0) driven by
// a mode-selected partition model; done pulses are checked against a queue.
module tb_partition_sweep_ctrl;

    localparam int unsigned NI = 7;
    localparam int unsigned NO = 4;
    localparam int unsigned EW = NI + 1;
    localparam int unsigned HW = NI + $clog2(NO + 1);

    typedef struct {
        int g;
        int err;
        int ham;
        int mx;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   mode = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    logic          start_s   [2];
    logic          abort_s   [2];
    logic [NI-1:0] pi_w      [2];
    logic [NO-1:0] po_e      [2];
    logic [NO-1:0] po_a      [2];
    logic          busy_w    [2];
    logic          done_w    [2];
    logic          rv_w      [2];
    logic [EW-1:0] err_w     [2];
    logic [HW-1:0] ham_w     [2];
    logic [NO-1:0] max_w     [2];
    int            acc       [2];
    bit            sweep_on  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int len_of(input int g);
        return (g == 0) ? 256 : 128;
    endfunction

    function automatic logic [3:0] f_ex(input int m, input logic [6:0] p);
        case (m)
            0:       return p[3:0] ^ p[6:3];
            1:       return 4'hF;
            2, 3, 4: return p[3:0];
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] f_ap(input int m, input logic [6:0] p);
        case (m)
            0:       return p[3:0] ^ p[6:3];
            1:       return 4'h0;
            2:       return (p == 7'h7F) ? (p[3:0] ^ 4'h8) : p[3:0];
            3:       return p[3:0] ^ {3'b000, p[0]};
            4:       return 4'h0;
            default: return {1'b0, p[2:0]};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    partition_sweep_ctrl #(.NI(NI), .NO(NO), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .pi(pi_w[0]), .po_exact(po_e[0]), .po_approx(po_a[0]),
        .busy(busy_w[0]), .done(done_w[0]), .result_valid(rv_w[0]),
        .err_cnt(err_w[0]), .ham_sum(ham_w[0]), .max_abs_err(max_w[0])
    );

    partition_sweep_ctrl #(.NI(NI), .NO(NO), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .pi(pi_w[1]), .po_exact(po_e[1]), .po_approx(po_a[1]),
        .busy(busy_w[1]), .done(done_w[1]), .result_valid(rv_w[1]),
        .err_cnt(err_w[1]), .ham_sum(ham_w[1]), .max_abs_err(max_w[1])
    );

    for (genvar g = 0; g < 2; g++) begin : mon
        assign po_e[g] = f_ex(mode, pi_w[g]);
        assign po_a[g] = f_ap(mode, pi_w[g]);

        // Pattern order and busy during a sweep
        always @(negedge clk) begin
            if (sweep_on[g] && ((cyc - acc[g]) < len_of(g))) begin
                total++;
                if (busy_w[g] !== 1'b1 || rv_w[g] !== 1'b0 ||
                    pi_w[g] !== NI'((cyc - acc[g]) / ((g == 0) ? 2 : 1))) begin
                    bad++;
                    $display("FAIL sweep[%0d] k=%0d: got busy=%b rv=%b pi=%0d expected busy=1 rv=0 pi=%0d",
                             g, cyc - acc[g], busy_w[g], rv_w[g], pi_w[g],
                             (cyc - acc[g]) / ((g == 0) ? 2 : 1));
                end
            end
        end

        // Scoreboard: every done pulse must match a queued expectation
        always @(negedge clk) begin
            if (done_w[g] === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_spurious[%0d]: got done=1 expected done=0", g);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("done_inst[%0d]", g), 64'(g), 64'(e.g));
                    chk($sformatf("done_cycle[%0d]", g), 64'(cyc), 64'(e.cyc));
                    chk($sformatf("err_cnt[%0d]", g), 64'(err_w[g]), 64'(e.err));
                    chk($sformatf("ham_sum[%0d]", g), 64'(ham_w[g]), 64'(e.ham));
                    chk($sformatf("max_abs_err[%0d]", g), 64'(max_w[g]), 64'(e.mx));
                    chk($sformatf("done_rv[%0d]", g), 64'(rv_w[g]), 64'd1);
                    chk($sformatf("done_busy[%0d]", g), 64'(busy_w[g]), 64'd0);
                    chk($sformatf("done_pi[%0d]", g), 64'(pi_w[g]), 64'h7F);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep(input int g);
        start_s[g] = 1'b1;
        tick();
        start_s[g] = 1'b0;
        acc[g] = cyc;
        sweep_on[g] = 1'b1;
    endtask

    task automatic run_sweep(input int g, input int m, input int e_err, input int e_ham,
                             input int e_mx, input bit repulse);
        bit found;
        mode = m;
        start_sweep(g);
        q.push_back('{g, e_err, e_ham, e_mx, acc[g] + len_of(g)});
        found = 1'b0;
        for (int i = 0; i < len_of(g) + 10; i++) begin
            tick();
            start_s[g] = (repulse && (cyc == acc[g] + 20)) ? 1'b1 : 1'b0;
            if (done_w[g] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        start_s[g] = 1'b0;
        sweep_on[g] = 1'b0;
        total++;
        if (!found) begin
            bad++;
            $display("FAIL done_timeout[%0d] mode=%0d: got no done expected done within %0d cycles",
                     g, m, len_of(g) + 10);
            q.delete();
        end
        tick();
        chk("post_done", 64'(done_w[g]), 64'd0);
        chk("post_busy", 64'(busy_w[g]), 64'd0);
        chk("post_pi", 64'(pi_w[g]), 64'd0);
        chk("post_rv", 64'(rv_w[g]), 64'd1);
        chk("post_err", 64'(err_w[g]), 64'(e_err));
        chk("post_ham", 64'(ham_w[g]), 64'(e_ham));
        chk("post_max", 64'(max_w[g]), 64'(e_mx));
    endtask

    task automatic chk_zero(input int g, input string tag);
        chk({tag, "_pi"}, 64'(pi_w[g]), 64'd0);
        chk({tag, "_busy"}, 64'(busy_w[g]), 64'd0);
        chk({tag, "_done"}, 64'(done_w[g]), 64'd0);
        chk({tag, "_rv"}, 64'(rv_w[g]), 64'd0);
        chk({tag, "_err"}, 64'(err_w[g]), 64'd0);
        chk({tag, "_ham"}, 64'(ham_w[g]), 64'd0);
        chk({tag, "_max"}, 64'(max_w[g]), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start_s[g] = 1'b0;
            abort_s[g] = 1'b0;
            acc[g] = 0;
            sweep_on[g] = 1'b0;
        end
        tick();
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        rst_n = 1'b1;
        tick();

        // Matched instances, with a start re-pulse mid-sweep that must be ignored
        run_sweep(0, 0, 0, 0, 0, 1'b1);
        run_sweep(0, 1, 128, 512, 15, 1'b0);
        run_sweep(0, 2, 1, 1, 8, 1'b0);
        run_sweep(0, 3, 64, 64, 1, 1'b0);
        run_sweep(0, 4, 120, 256, 15, 1'b0);
        run_sweep(0, 5, 112, 192, 7, 1'b0);
        run_sweep(1, 4, 120, 256, 15, 1'b0);

        // Abort at cycle 50, then a clean full sweep
        mode = 1;
        start_sweep(0);
        while (cyc < acc[0] + 50) tick();
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        sweep_on[0] = 1'b0;
        chk("abort_busy", 64'(busy_w[0]), 64'd0);
        chk("abort_pi", 64'(pi_w[0]), 64'd0);
        chk("abort_rv", 64'(rv_w[0]), 64'd0);
        chk("abort_done", 64'(done_w[0]), 64'd0);
        repeat (20) tick();
        run_sweep(0, 3, 64, 64, 1, 1'b0);

        // Start together with abort in IDLE: start must not be accepted
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        chk("both_busy", 64'(busy_w[0]), 64'd0);
        chk("both_err_kept", 64'(err_w[0]), 64'd64);
        tick();
        chk("both_busy2", 64'(busy_w[0]), 64'd0);

        // Reset mid-sweep with start held during reset
        mode = 1;
        start_sweep(0);
        while (cyc < acc[0] + 100) tick();
        rst_n = 1'b0;
        start_s[0] = 1'b1;
        tick();
        sweep_on[0] = 1'b0;
        chk_zero(0, "midrst");
        tick();
        chk("rst_start_busy", 64'(busy_w[0]), 64'd0);
        rst_n = 1'b1;
        start_s[0] = 1'b0;
        tick();
        chk("after_rst_busy", 64'(busy_w[0]), 64'd0);
        chk("after_rst_pi", 64'(pi_w[0]), 64'd0);
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/partition_sweep_ctrl.md
PARTITION_SWEEP_CTRL -- requirements
Module: partition_sweep_ctrl

Interface
REQ-001 SHALL have parameter NI, default 7, partition primary-input width.
REQ-002 SHALL have parameter NO, default 4, partition primary-output width.
REQ-003 SHALL have parameter SETTLE, default 1, idle cycles between driving a pattern and sampling it (0..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request a full exhaustive sweep.
REQ-007 SHALL have port abort  input  1  cancel a sweep in progress.
REQ-008 SHALL have port pi  output  NI  pattern driven to both exact and approximate partition instances.
REQ-009 SHALL have port po_exact  input  NO  exact partition response to pi.
REQ-010 SHALL have port po_approx  input  NO  approximate partition response to pi.
REQ-011 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-013 SHALL have port result_valid  output  1  metrics hold a complete-sweep result.
REQ-014 SHALL have port err_cnt  output  NI+1  count of patterns with po_exact != po_approx.
REQ-015 SHALL have port ham_sum  output  NI+$clog2(NO+1)  sum over patterns of popcount(po_exact ^ po_approx).
REQ-016 SHALL have port max_abs_err  output  NO  maximum over patterns of |po_exact - po_approx| as unsigned values.

Function
REQ-017 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-018 IDLE: pi=0, busy=0; start=1 and abort=0 SHALL clear err_cnt/ham_sum/max_abs_err, clear result_valid, load pi=0, go to SETTLE (SETTLE>0) or SAMPLE (SETTLE=0).
REQ-019 SETTLE SHALL hold pi for exactly SETTLE cycles, then go to SAMPLE.
REQ-020 SAMPLE SHALL, on the edge leaving it, accumulate the current pattern: err_cnt+1 if any bit differs; ham_sum += popcount(xor); max_abs_err = max(max_abs_err, |exact-approx|).
REQ-021 SAMPLE with pi != all-ones SHALL increment pi and return to SETTLE (or SAMPLE if SETTLE=0); with pi == all-ones SHALL go to DONE with pi unchanged.
REQ-022 DONE SHALL last one cycle: done=1, result_valid=1, busy=0, then IDLE; pi returns to 0 in IDLE.
REQ-023 busy SHALL be 1 in SETTLE and SAMPLE only.
REQ-024 done SHALL be high in the cycle following the 2^NI*(SETTLE+1)-th rising edge after the edge that accepted start (257th cycle for defaults).
REQ-025 Each pattern 0..2^NI-1 SHALL be sampled exactly once, in ascending order; no wrap-around past all-ones.
REQ-026 start while busy or in DONE SHALL be ignored.
REQ-027 abort in SETTLE or SAMPLE SHALL go to IDLE on the next edge, result_valid=0, no done pulse, no accumulation for the current pattern; partial metrics retained but invalid.
REQ-028 start and abort together in IDLE: abort wins, start ignored.
REQ-029 result_valid and metrics SHALL hold after DONE until the next accepted start, abort or reset.
REQ-030 Accumulators SHALL never overflow (widths cover 2^NI patterns, NO bits each); no saturation logic required.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, pi=0, busy=0, done=0, result_valid=0, err_cnt=0, ham_sum=0, max_abs_err=0, regardless of state, including mid-sweep.
REQ-032 start SHALL be ignored in any cycle where rst_n=0.

Verification
REQ-033 po_approx tied to po_exact, start pulse -> done on 257th cycle after accept, err_cnt=0, ham_sum=0, max_abs_err=0, result_valid=1.
REQ-034 po_exact=4'hF, po_approx=4'h0 constant -> err_cnt=128, ham_sum=512, max_abs_err=15.
REQ-035 po_approx = po_exact ^ 4'h8 only when pi==7'h7F -> err_cnt=1, ham_sum=1, max_abs_err=8 (last pattern sampled before done).
REQ-036 abort at cycle 50 of sweep -> busy=0 next cycle, pi=0, done never pulses, result_valid=0; subsequent start gives correct full-sweep result.
REQ-037 start re-pulsed at cycle 20 of sweep -> ignored, done still on cycle 257; rst_n low at cycle 100 -> all outputs zero next cycle, no done pulse.
REQ-038 SETTLE=0 build, identical inputs -> done on 129th cycle after accept, pi advances every cycle.
